// File: rtl/bat_register_file_if.sv
// Strobe/bus/FIFO bundle between the controller (master) and the register file (slave).
// Signal names follow the controller's existing per-register strobe interface.
interface bat_register_file_if #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       REGS_INC;
    logic [7:0]       REGS_RW;
    logic [7:0]       REGS_EN;
    logic [WIDTH-1:0] BUS_IN;
    logic [WIDTH-1:0] BUS_OUT;
    logic             BUS_DRIVE;
    logic             BUS_ERR;
    logic [WIDTH-1:0] A_OUT;
    logic [WIDTH-1:0] B_OUT;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [LW-1:0]    OUT_LEVEL;
    logic             OUT_OVF;

    modport master (
        output REGS_INC, REGS_RW, REGS_EN, BUS_IN, OUT_READY,
        input  BUS_OUT, BUS_DRIVE, BUS_ERR, A_OUT, B_OUT,
        input  OUT_DATA, OUT_VALID, OUT_LEVEL, OUT_OVF
    );

    modport slave (
        input  REGS_INC, REGS_RW, REGS_EN, BUS_IN, OUT_READY,
        output BUS_OUT, BUS_DRIVE, BUS_ERR, A_OUT, B_OUT,
        output OUT_DATA, OUT_VALID, OUT_LEVEL, OUT_OVF
    );
endinterface

// File: rtl/bat_register_file.sv
// Eight general registers answering per-register INC/RW/EN strobes on a shared bus;
// every update of register OUT_IDX is queued in a small FIFO for an external consumer.
module bat_register_file #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int OUT_IDX    = 7
) (
    input logic                 CLK,
    input logic                 RST,
    bat_register_file_if.slave  rf_if
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic [WIDTH-1:0] mem_q  [FIFO_DEPTH];
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;

    logic [7:0]       load_s;
    logic [7:0]       drive_s;
    logic [WIDTH-1:0] bus_out_s;
    logic             bus_err_s;
    logic             push_s;
    logic [WIDTH-1:0] push_data_s;
    logic [LW-1:0]    level_s;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             wr_en_s;

    assign load_s  = rf_if.REGS_EN & ~rf_if.REGS_RW;
    assign drive_s = rf_if.REGS_EN &  rf_if.REGS_RW;

    // Register next state: a load takes priority over an increment on the same register.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (load_s[i]) begin
                regs_d[i] = rf_if.BUS_IN;
            end else if (rf_if.REGS_INC[i]) begin
                regs_d[i] = regs_q[i] + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Bus read-out: scan from the top so the lowest-index driver ends up on the bus.
    always_comb begin
        bus_out_s = {WIDTH{1'b0}};
        for (int i = 7; i >= 0; i--) begin
            bus_out_s = drive_s[i] ? regs_q[i] : bus_out_s;
        end
        bus_err_s = ((drive_s & (drive_s - 8'd1)) != 8'd0);
    end

    assign push_s      = load_s[OUT_IDX] | rf_if.REGS_INC[OUT_IDX];
    assign push_data_s = regs_d[OUT_IDX];
    assign level_s     = wr_ptr_q - rd_ptr_q;
    assign empty_s     = (level_s == {LW{1'b0}});
    assign full_s      = (level_s == LW'(FIFO_DEPTH));
    assign pop_s       = ~empty_s & rf_if.OUT_READY;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign wr_en_s     = push_s & (~full_s | pop_s);

    // FIFO pointer and sticky overflow next state.
    always_comb begin
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + {{(LW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(LW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        ovf_d = ovf_q | (push_s & full_s & ~pop_s);
    end

    // Register bank, FIFO pointers and overflow flag with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {LW{1'b0}};
            rd_ptr_q <= {LW{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are only observed through the pointers, so no reset needed.
    always_ff @(posedge CLK) begin
        if (RST && wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_s;
        end
    end

    assign rf_if.BUS_OUT   = bus_out_s;
    assign rf_if.BUS_DRIVE = |drive_s;
    assign rf_if.BUS_ERR   = bus_err_s;
    assign rf_if.A_OUT     = regs_q[0];
    assign rf_if.B_OUT     = regs_q[1];
    assign rf_if.OUT_DATA  = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];
    assign rf_if.OUT_VALID = ~empty_s;
    assign rf_if.OUT_LEVEL = level_s;
    assign rf_if.OUT_OVF   = ovf_q;
endmodule

// File: doc/bat_register_file.md
Name: bat_register_file

Overview:
- Responder side of the controller's per-register strobe interface: eight WIDTH-bit general registers, indices 0..7 = A, B, R3, R4, R5, R6, R7, OUT.
- Each register obeys its INC/RW/EN strobe bits; registers drive or load the shared data bus.
- Registers A and B feed the ALU directly.
- Every update of the OUT register (index OUT_IDX) is pushed into a small output FIFO, drained by an external device with a valid/ready handshake.

Parameters:
- WIDTH, 8, data width of registers and bus
- FIFO_DEPTH, 4, OUT FIFO entries (power of 2, >=2)
- OUT_IDX, 7, index of the register that feeds the OUT FIFO

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset, active-low
- REGS_INC  in  8  per-register increment strobe
- REGS_RW  in  8  per-register direction: 1 = drive bus (read out), 0 = load from bus (write)
- REGS_EN  in  8  per-register bus enable
- BUS_IN  in  WIDTH  bus value sampled on loads
- BUS_OUT  out  WIDTH  value driven by the selected register; 0 when none
- BUS_DRIVE  out  1  high when any register drives the bus
- BUS_ERR  out  1  high when more than one register drives in the same cycle
- A_OUT  out  WIDTH  register 0 contents
- B_OUT  out  WIDTH  register 1 contents
- OUT_DATA  out  WIDTH  FIFO head
- OUT_VALID  out  1  FIFO non-empty
- OUT_READY  in  1  consumer accepts head
- OUT_LEVEL  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- OUT_OVF  out  1  sticky overflow flag

Behaviour:
- Reset (RST=0 at a rising edge):
  - All registers become 0; FIFO becomes empty; OUT_OVF clears.
  - Strobes are ignored during that cycle.
  - Outputs after reset: BUS_OUT=0, BUS_DRIVE=0, BUS_ERR=0, A_OUT=B_OUT=0, OUT_DATA=0, OUT_VALID=0, OUT_LEVEL=0.
- Reset mid-operation discards all FIFO contents.
- Read out (combinational, zero latency), register i with EN[i]=1 and RW[i]=1:
  - i drives the bus. BUS_DRIVE = OR over all drivers.
  - With two or more drivers, BUS_ERR=1 and BUS_OUT = lowest-index driver.
- Load, EN[i]=1 and RW[i]=0: register i <= BUS_IN at the rising edge. The new value is visible the next cycle.
- Increment, INC[i]=1: register i <= register i + 1 modulo 2^WIDTH (0xFF -> 0x00). Applies regardless of EN[i] and RW[i].
- Load and INC on the same register in the same cycle: the load wins and INC is ignored.
- Read-out and INC on the same register in the same cycle: the bus carries the pre-increment value and the register increments.
- A register may drive the bus while another loads in the same cycle. The loaded value is BUS_IN; there is no internal loopback.
- OUT FIFO push:
  - Occurs at any edge where register OUT_IDX is loaded or incremented.
  - The pushed data is the new register value.
  - Write pointer and read pointer are each clog2(FIFO_DEPTH)+1 bits and wrap naturally.
- OUT FIFO pop: occurs at an edge with OUT_VALID=1 and OUT_READY=1. OUT_READY while empty is ignored.
- Latency: a push into an empty FIFO gives OUT_VALID=1 and OUT_DATA=value in the next cycle. There is no fall-through in the same cycle.
- Push and pop in the same cycle:
  - Both occur and the level is unchanged.
  - This applies when the FIFO is full: the pop frees the slot and there is no overflow.
- Push while full with no pop: data is dropped, OUT_OVF is set, and the FIFO is unchanged. OUT_OVF stays high until reset.
- OUT_DATA is 0 when the FIFO is empty.
- OUT_LEVEL ranges from 0 to FIFO_DEPTH.

Test Plan:
- Reset then idle:
  - RST=0 one cycle, all strobes 0 -> A_OUT=B_OUT=0, BUS_DRIVE=0, OUT_VALID=0, OUT_LEVEL=0, OUT_OVF=0.
- Load and read:
  - BUS_IN=0x5A, EN[3]=1, RW[3]=0 for one cycle.
  - Next cycle EN[3]=1, RW[3]=1 -> BUS_OUT=0x5A, BUS_DRIVE=1, BUS_ERR=0.
  - Load A with 0x12 -> A_OUT=0x12 the next cycle.
- Increment wrap and priority:
  - Load B=0xFF, then INC[1]=1 -> B_OUT=0x00.
  - Same cycle INC[1]=1, EN[1]=1, RW[1]=0, BUS_IN=0x40 -> B_OUT=0x40.
- Bus conflict:
  - R4=0x11, R5=0x22, both with EN=1, RW=1 -> BUS_ERR=1, BUS_OUT=0x11.
- OUT FIFO ordering:
  - Load OUT with 0x01, 0x02, 0x03 with OUT_READY=0 -> OUT_LEVEL=3, OUT_DATA=0x01.
  - Then OUT_READY=1 -> 0x01, 0x02, 0x03 are popped on successive cycles, then OUT_VALID=0.
- Overflow and full push/pop:
  - Fill 4 entries (0xA0..0xA3). A 5th load of 0xA4 with OUT_READY=0 -> OUT_OVF=1, level stays 4, head 0xA0.
  - Refill to full, then push 0xB0 with OUT_READY=1 -> level stays 4, 0xB0 becomes the tail entry, OUT_OVF stays 1 until RST=0.
